// File: rtl/cpu_mem_pkg.sv
// Shared load/store width codes and responder FSM state type.
// Imported by the main decoder and by data_mem_responder.
package cpu_mem_pkg;

  localparam logic [1:0] ST_W    = 2'b00;
  localparam logic [1:0] ST_H    = 2'b01;
  localparam logic [1:0] ST_B    = 2'b10;
  localparam logic [1:0] ST_RSVD = 2'b11;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } mem_state_e;

  // Right-justify the addressed lane, then sign/zero extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  code);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (code)
      LD_B:    return {{24{lane[7]}}, lane[7:0]};
      LD_H:    return {{16{lane[15]}}, lane[15:0]};
      LD_BU:   return {24'h0, lane[7:0]};
      LD_HU:   return {16'h0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

endpackage

// File: rtl/mem_ram_be.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables.
// Read data is registered: valid the cycle after re is sampled.
module mem_ram_be #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder over a byte-enable RAM; store response 1 cycle after accept, load 2; one request in flight.
// Response holds while rsp_ready is low. Define MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_store,
  input  logic [2:0]        req_load,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mem_state_e  state, state_nx;
  logic        accept, is_half, is_word, code_err, range_err, misalign, err_now;
  logic [1:0]  off, off_q;
  logic [2:0]  load_q;
  logic [3:0]  be;
  logic [31:0] wdata_rep, ram_rdata;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    is_half  = 1'b0;
    is_word  = 1'b0;
    code_err = 1'b0;
    if (req_we) begin
      is_half  = (req_store == ST_H);
      is_word  = (req_store == ST_W);
      code_err = (req_store == ST_RSVD);
    end else begin
      is_half  = (req_load == LD_H) || (req_load == LD_HU);
      is_word  = (req_load == LD_W);
      code_err = (req_load > LD_HU);
    end
  end

  assign range_err = (req_addr >> (AW + 2)) != '0;

`ifdef MISALIGN_TRAP_EN
  assign misalign = is_word ? (req_addr[1:0] != 2'b00) : (is_half && req_addr[0]);
`else
  assign misalign = 1'b0;
`endif

  assign err_now = range_err || code_err || misalign;

  // Byte offset after forcing natural alignment; only matters when no fault is raised.
  always_comb begin
    off = req_addr[1:0];
    if (is_word)      off = 2'b00;
    else if (is_half) off = {req_addr[1], 1'b0};
  end

  always_comb begin
    be        = 4'b1111;
    wdata_rep = req_wdata;
    case (req_store)
      ST_B: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      ST_H: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  mem_ram_be #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (accept && req_we && !err_now),
    .re   (accept && !req_we),
    .be   (be),
    .addr (req_addr[AW+1:2]),
    .wdata(wdata_rep),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req_valid) state_nx = req_we ? S_RESP : S_READ;
      S_READ:  state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      off_q     <= 2'b00;
      load_q    <= LD_W;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        off_q     <= off;
        load_q    <= req_load;
        rsp_rdata <= '0;
        rsp_err   <= err_now;
      end else if (state == S_READ && !rsp_err) begin
        rsp_rdata <= load_extract(ram_rdata, off_q, load_q);
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed table, byte-array reference model with random traffic, and handshake/reset corner sequences.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam logic [31:0] TOP = 32'(4 * DEPTH);
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_store = 2'b00;
  logic [2:0]  req_load = 3'b010;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [4*DEPTH];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  st;
    logic [2:0]  ld;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_store(req_store),
    .req_load (req_load),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: flat byte-addressed memory, access size from the width code.
  task automatic model(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] st, input logic [2:0] ld,
                       output logic [31:0] rd, output logic er);
    int size;
    bit sgn, resv;
    logic [31:0] a, v;
    size = 4; sgn = 0; resv = 0;
    if (we) begin
      case (st)
        2'd0: size = 4;
        2'd1: size = 2;
        2'd2: size = 1;
        default: resv = 1;
      endcase
    end else begin
      case (ld)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd3: size = 1;
        3'd4: size = 2;
        default: resv = 1;
      endcase
    end
    er = resv || (addr >= TOP);
    a  = addr;
    if (addr % 32'(size) != 0) begin
      if (TRAP) er = 1'b1;
      else      a  = addr - (addr % 32'(size));
    end
    rd = '0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[a + 32'(i)] = wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[a + 32'(i)];
        if (sgn && v[8*size-1])
          for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
        rd = v;
      end
    end
  endtask

  task automatic drive(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] st, input logic [2:0] ld);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wdata; req_store = st; req_load = ld;
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] st, input logic [2:0] ld, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    drive(we, addr, wdata, st, ld);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  function automatic void add(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] st, input logic [2:0] ld,
                              input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.st = st; v.ld = ld;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [31:0] rd, mrd, held;
    logic        er, mer;
    int          lat, n;
    bit          we;
    logic [31:0] addr;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);

    // Fill the whole RAM so every later load has a known answer.
    for (int w = 0; w < DEPTH; w++) begin
      addr = 32'(4 * w);
      mrd = $urandom;
      model(1'b1, addr, mrd, 2'd0, 3'd2, rd, mer);
      do_req(1'b1, addr, mrd, 2'd0, 3'd2, 0, rd, er, lat);
      chk("init_err", 32'(er), 32'd0);
    end

    add(1, 32'h00, 32'hCAFEF00D, 2'd0, 3'd2, 32'h0, 0, 1);
    add(1, 32'h10, 32'hDEADBEEF, 2'd0, 3'd2, 32'h0, 0, 1);
    add(0, 32'h10, 32'h0, 2'd0, 3'd2, 32'hDEADBEEF, 0, 2);
    add(1, 32'h13, 32'h80, 2'd2, 3'd2, 32'h0, 0, 1);
    add(0, 32'h13, 32'h0, 2'd0, 3'd0, 32'hFFFFFF80, 0, 2);
    add(0, 32'h13, 32'h0, 2'd0, 3'd3, 32'h00000080, 0, 2);
    add(0, 32'h10, 32'h0, 2'd0, 3'd2, 32'h80ADBEEF, 0, 2);
    add(0, 32'h10, 32'h0, 2'd0, 3'd0, 32'hFFFFFFEF, 0, 2);
    add(0, 32'h12, 32'h0, 2'd0, 3'd4, 32'h000080AD, 0, 2);
    add(1, 32'h11, 32'h1234, 2'd1, 3'd2, 32'h0, TRAP, 1);
    add(0, 32'h10, 32'h0, 2'd0, 3'd2, TRAP ? 32'h80ADBEEF : 32'h80AD1234, 0, 2);
    add(0, 32'h10, 32'h0, 2'd0, 3'd1, TRAP ? 32'hFFFFBEEF : 32'h00001234, 0, 2);
    add(0, TOP, 32'h0, 2'd0, 3'd2, 32'h0, 1, 2);
    add(1, TOP, 32'h55555555, 2'd0, 3'd2, 32'h0, 1, 1);
    add(0, 32'h00, 32'h0, 2'd0, 3'd2, 32'hCAFEF00D, 0, 2);
    add(1, 32'h20, 32'h11111111, 2'd3, 3'd2, 32'h0, 1, 1);
    add(0, 32'h00, 32'h0, 2'd0, 3'd5, 32'h0, 1, 2);
    add(1, 32'h22, 32'h8001, 2'd1, 3'd2, 32'h0, 0, 1);
    add(0, 32'h22, 32'h0, 2'd0, 3'd1, 32'hFFFF8001, 0, 2);
    add(0, 32'h11, 32'h0, 2'd0, 3'd2, TRAP ? 32'h0 : 32'h80AD1234, TRAP, 2);

    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].st, tbl[i].ld, mrd, mer);
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].st, tbl[i].ld, 0, rd, er, lat);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
    end

    // Backpressure: response held for 3 cycles must stay put.
    model(1'b0, 32'h10, 32'h0, 2'd0, 3'd2, mrd, mer);
    drive(1'b0, 32'h10, 32'h0, 2'd0, 3'd2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    held = rsp_rdata;
    chk("bp_rdata", held, mrd);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_rdata_held", rsp_rdata, held);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_done_valid", 32'(rsp_valid), 32'd0);
    chk("bp_done_ready", 32'(req_ready), 32'd1);

    // New request offered while the response completes: accepted only from IDLE.
    drive(1'b0, 32'h20, 32'h0, 2'd0, 3'd2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    drive(1'b1, 32'h24, 32'hA5A5_5A5A, 2'd0, 3'd2);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("overlap_valid_low", 32'(rsp_valid), 32'd0);
    chk("overlap_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    model(1'b1, 32'h24, 32'hA5A5_5A5A, 2'd0, 3'd2, mrd, mer);
    chk("overlap_accept_valid", 32'(rsp_valid), 32'd1);
    chk("overlap_accept_busy", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    model(1'b0, 32'h24, 32'h0, 2'd0, 3'd2, mrd, mer);
    do_req(1'b0, 32'h24, 32'h0, 2'd0, 3'd2, 0, rd, er, lat);
    chk("overlap_readback", rd, mrd);

    // Reset while a load is in READ.
    drive(1'b0, 32'h10, 32'h0, 2'd0, 3'd2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_after_valid", 32'(rsp_valid), 32'd0);
    model(1'b0, 32'h10, 32'h0, 2'd0, 3'd2, mrd, mer);
    do_req(1'b0, 32'h10, 32'h0, 2'd0, 3'd2, 0, rd, er, lat);
    chk("rst_after_lw", rd, mrd);
    chk("rst_after_err", 32'(er), 32'd0);

    // Random traffic against the byte-array model.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] wd;
      logic [1:0]  st;
      logic [2:0]  ld;
      we   = ($urandom_range(0, 1) == 1);
      addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH + 15));
      wd   = $urandom;
      st   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ld   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      model(we, addr, wd, st, ld, mrd, mer);
      do_req(we, addr, wd, st, ld, $urandom_range(0, 2), rd, er, lat);
      chk($sformatf("rnd%0d_rdata", k), rd, mrd);
      chk($sformatf("rnd%0d_err", k), 32'(er), 32'(mer));
      chk($sformatf("rnd%0d_lat", k), 32'(lat), we ? 32'd1 : 32'd2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
